// File: rtl/updown_pkg.sv
// rtl/updown_pkg.sv - shared mode and state encodings for the up/down sequencer
package updown_pkg;

    // Command modes as carried on cmd_mode
    typedef enum logic [1:0] {
        MODE_UP     = 2'd0,
        MODE_DOWN   = 2'd1,
        MODE_BOUNCE = 2'd2,
        MODE_LOAD   = 2'd3
    } mode_e;

    // Sequencer FSM states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/updown_seq_ctrl_if.sv
// rtl/updown_seq_ctrl_if.sv - command handshake and status bundle for the sequencer
interface updown_seq_ctrl_if #(
    parameter int WIDTH  = 3,
    parameter int STEP_W = 8,
    parameter int DIV_W  = 8
) ();
    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_mode;
    logic [WIDTH-1:0]  cmd_lo;
    logic [WIDTH-1:0]  cmd_hi;
    logic [STEP_W-1:0] cmd_steps;
    logic [DIV_W-1:0]  cmd_div;
    logic              abort;
    logic [WIDTH-1:0]  count;
    logic              dir;
    logic              busy;
    logic              done;
    logic              err;

    // System controller side: issues commands, observes status
    modport master (
        output cmd_valid, cmd_mode, cmd_lo, cmd_hi, cmd_steps, cmd_div, abort,
        input  cmd_ready, count, dir, busy, done, err
    );

    // Sequencer side
    modport slave (
        input  cmd_valid, cmd_mode, cmd_lo, cmd_hi, cmd_steps, cmd_div, abort,
        output cmd_ready, count, dir, busy, done, err
    );
endinterface

// File: rtl/updown_rate_div.sv
// rtl/updown_rate_div.sv - loadable down-counter that paces sequencer steps
module updown_rate_div #(
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             en,
    input  logic [DIV_W-1:0] load_val,
    output logic             zero
);
    logic [DIV_W-1:0] cnt;

    // Load has priority; otherwise count down while enabled and parked at zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (en && (cnt != '0)) begin
            cnt <= cnt - DIV_W'(1);
        end
    end

    assign zero = (cnt == '0);
endmodule

// File: rtl/updown_seq_ctrl.sv
// rtl/updown_seq_ctrl.sv - command-driven up/down/bounce count sequencer
module updown_seq_ctrl
    import updown_pkg::*;
#(
    parameter int WIDTH  = 3,
    parameter int STEP_W = 8,
    parameter int DIV_W  = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    updown_seq_ctrl_if.slave bus
);
    state_e            state, state_n;
    mode_e             cmd_mode_e;
    mode_e             mode_q;
    logic [WIDTH-1:0]  count_q, lo_q, hi_q;
    logic              dir_q;
    logic [STEP_W-1:0] rem_q;
    logic [DIV_W-1:0]  div_q;
    logic              err_q;

    logic              accept, is_load, bad, start, step, div_zero;
    logic [WIDTH-1:0]  clamp_count, step_count;
    logic              step_dir;

    assign cmd_mode_e = mode_e'(bus.cmd_mode);
    assign accept     = bus.cmd_valid && (state == ST_IDLE);
    assign is_load    = accept && (cmd_mode_e == MODE_LOAD);
    assign bad        = accept && (cmd_mode_e != MODE_LOAD) && (bus.cmd_lo > bus.cmd_hi);
    assign start      = accept && (cmd_mode_e != MODE_LOAD) && !(bus.cmd_lo > bus.cmd_hi);
    // Abort wins over a step landing on the same edge
    assign step       = (state == ST_RUN) && div_zero && !bus.abort;

    updown_rate_div #(.DIV_W(DIV_W)) u_rate_div (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (start || step),
        .en       ((state == ST_RUN) && !div_zero),
        .load_val (start ? bus.cmd_div : div_q),
        .zero     (div_zero)
    );

    // Pull an out-of-window count to the edge the mode starts moving from
    always_comb begin
        clamp_count = count_q;
        if ((count_q < bus.cmd_lo) || (count_q > bus.cmd_hi)) begin
            clamp_count = (cmd_mode_e == MODE_DOWN) ? bus.cmd_hi : bus.cmd_lo;
        end
    end

    // Next count/direction for one step; wrap and reversal stay inside [lo,hi]
    always_comb begin
        step_count = count_q;
        step_dir   = dir_q;
        case (mode_q)
            MODE_UP:   step_count = (count_q == hi_q) ? lo_q : count_q + WIDTH'(1);
            MODE_DOWN: step_count = (count_q == lo_q) ? hi_q : count_q - WIDTH'(1);
            MODE_BOUNCE: begin
                if (lo_q == hi_q) begin
                    step_dir = !dir_q;
                end else if (dir_q) begin
                    if (count_q == hi_q) begin
                        step_dir   = 1'b0;
                        step_count = count_q - WIDTH'(1);
                    end else begin
                        step_count = count_q + WIDTH'(1);
                    end
                end else begin
                    if (count_q == lo_q) begin
                        step_dir   = 1'b1;
                        step_count = count_q + WIDTH'(1);
                    end else begin
                        step_count = count_q - WIDTH'(1);
                    end
                end
            end
            default: ;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // FSM next state and status outputs
    always_comb begin
        state_n       = state;
        bus.cmd_ready = (state == ST_IDLE);
        bus.busy      = (state != ST_IDLE);
        bus.done      = (state == ST_DONE);
        case (state)
            ST_IDLE: begin
                if (is_load) begin
                    state_n = ST_DONE;
                end else if (start) begin
                    state_n = (bus.cmd_steps == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (bus.abort) begin
                    state_n = ST_IDLE;
                end else if (step && (rem_q == STEP_W'(1))) begin
                    state_n = ST_DONE;
                end
            end
            ST_DONE: state_n = ST_IDLE;
            default: state_n = ST_IDLE;
        endcase
    end

    // Datapath: command latch, clamp/load on accept, stepping in RUN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
            dir_q   <= 1'b1;
            lo_q    <= '0;
            hi_q    <= '0;
            mode_q  <= MODE_UP;
            rem_q   <= '0;
            div_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            err_q <= bad;
            if (is_load) begin
                count_q <= bus.cmd_lo;
            end else if (start) begin
                lo_q    <= bus.cmd_lo;
                hi_q    <= bus.cmd_hi;
                mode_q  <= cmd_mode_e;
                rem_q   <= bus.cmd_steps;
                div_q   <= bus.cmd_div;
                count_q <= clamp_count;
                dir_q   <= (cmd_mode_e != MODE_DOWN);
            end else if (step) begin
                count_q <= step_count;
                dir_q   <= step_dir;
                rem_q   <= rem_q - STEP_W'(1);
            end
        end
    end

    assign bus.count = count_q;
    assign bus.dir   = dir_q;
    assign bus.err   = err_q;
endmodule

// File: tb/tb_updown_seq_ctrl.sv
// tb/tb_updown_seq_ctrl.sv - directed scoreboard bench for updown_seq_ctrl
module tb_updown_seq_ctrl;
    typedef struct {
        logic [2:0] c;
        logic       d;
        int         cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   done_cnt = 0;
    int   rdy_low = 0;
    bit   mon_en = 1'b0;
    logic [2:0] prev_count = '0;
    logic       prev_dir = 1'b1;
    logic       prev_busy = 1'b0;
    exp_t sb[$];

    updown_seq_ctrl_if #(.WIDTH(3), .STEP_W(8), .DIV_W(8)) u_if ();

    updown_seq_ctrl #(.WIDTH(3), .STEP_W(8), .DIV_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (u_if)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [2:0] c, input logic d, input int at);
        exp_t e;
        e.c = c;
        e.d = d;
        e.cyc = at;
        sb.push_back(e);
    endtask

    task automatic issue(input logic [1:0] m, input logic [2:0] lo, input logic [2:0] hi,
                         input logic [7:0] st, input logic [7:0] dv, output int acc);
        @(negedge clk);
        u_if.cmd_mode  = m;
        u_if.cmd_lo    = lo;
        u_if.cmd_hi    = hi;
        u_if.cmd_steps = st;
        u_if.cmd_div   = dv;
        u_if.cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        acc = cyc;
        u_if.cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!u_if.busy && sb.size() == 0) break;
        end
        check(tag, int'(u_if.busy) + sb.size(), 0);
    endtask

    // Step monitor: any count/dir change while already busy is a step
    always @(negedge clk) begin
        exp_t e;
        if (mon_en && prev_busy && (u_if.count !== prev_count || u_if.dir !== prev_dir)) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL unexpected_step count=%0d dir=%0d cyc=%0d", u_if.count, u_if.dir, cyc);
            end else begin
                e = sb.pop_front();
                check("step_count", int'(u_if.count), int'(e.c));
                check("step_dir", int'(u_if.dir), int'(e.d));
                check("step_cycle", cyc, e.cyc);
            end
        end
        if (u_if.done === 1'b1) done_cnt++;
        if (u_if.cmd_ready === 1'b0) rdy_low++;
        prev_count <= u_if.count;
        prev_dir   <= u_if.dir;
        prev_busy  <= u_if.busy;
    end

    initial begin
        int acc;
        int d0;
        u_if.cmd_valid = 1'b0;
        u_if.cmd_mode  = 2'd0;
        u_if.cmd_lo    = '0;
        u_if.cmd_hi    = '0;
        u_if.cmd_steps = '0;
        u_if.cmd_div   = '0;
        u_if.abort     = 1'b0;

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_count", int'(u_if.count), 0);
        check("rst_dir", int'(u_if.dir), 1);
        check("rst_busy", int'(u_if.busy), 0);
        check("rst_done", int'(u_if.done), 0);
        check("rst_err", int'(u_if.err), 0);
        check("rst_ready", int'(u_if.cmd_ready), 1);
        rst_n = 1'b1;
        @(negedge clk);
        mon_en = 1'b1;

        // UP 2..5, 6 steps, div 0, clamp from 0
        d0 = done_cnt;
        issue(2'd0, 3'd2, 3'd5, 8'd6, 8'd0, acc);
        check("up_clamp", int'(u_if.count), 2);
        check("up_busy", int'(u_if.busy), 1);
        push(3'd3, 1'b1, acc + 1); push(3'd4, 1'b1, acc + 2); push(3'd5, 1'b1, acc + 3);
        push(3'd2, 1'b1, acc + 4); push(3'd3, 1'b1, acc + 5); push(3'd4, 1'b1, acc + 6);
        wait_idle("up_idle");
        check("up_done_pulses", done_cnt - d0, 1);
        check("up_final", int'(u_if.count), 4);
        check("up_dir", int'(u_if.dir), 1);

        // BOUNCE 1..3, 5 steps, div 1, clamp 4 -> 1
        d0 = done_cnt;
        issue(2'd2, 3'd1, 3'd3, 8'd5, 8'd1, acc);
        check("bounce_clamp", int'(u_if.count), 1);
        push(3'd2, 1'b1, acc + 2); push(3'd3, 1'b1, acc + 4); push(3'd2, 1'b0, acc + 6);
        push(3'd1, 1'b0, acc + 8); push(3'd2, 1'b1, acc + 10);
        wait_idle("bounce_idle");
        check("bounce_done_pulses", done_cnt - d0, 1);
        check("bounce_final", int'(u_if.count), 2);
        check("bounce_dir", int'(u_if.dir), 1);

        // LOAD 1 as setup, then DOWN 0..7, 3 steps
        issue(2'd3, 3'd1, 3'd0, 8'd0, 8'd0, acc);
        check("load1_count", int'(u_if.count), 1);
        wait_idle("load1_idle");
        d0 = done_cnt;
        rdy_low = 0;
        issue(2'd1, 3'd0, 3'd7, 8'd3, 8'd0, acc);
        check("down_dir", int'(u_if.dir), 0);
        push(3'd0, 1'b0, acc + 1); push(3'd7, 1'b0, acc + 2); push(3'd6, 1'b0, acc + 3);
        wait_idle("down_idle");
        repeat (2) @(negedge clk);
        check("down_ready_low", rdy_low, 4);
        check("down_done_pulses", done_cnt - d0, 1);
        check("down_final", int'(u_if.count), 6);

        // Rejected command: lo > hi
        issue(2'd0, 3'd5, 3'd2, 8'd4, 8'd0, acc);
        check("err_pulse", int'(u_if.err), 1);
        check("err_busy", int'(u_if.busy), 0);
        check("err_ready", int'(u_if.cmd_ready), 1);
        check("err_count", int'(u_if.count), 6);
        check("err_dir", int'(u_if.dir), 0);
        @(posedge clk); #1;
        check("err_one_cycle", int'(u_if.err), 0);

        // UP 0..7, 10 steps, div 3, abort on the 3rd step edge
        d0 = done_cnt;
        issue(2'd0, 3'd0, 3'd7, 8'd10, 8'd3, acc);
        push(3'd7, 1'b1, acc + 4); push(3'd0, 1'b1, acc + 8);
        while (cyc < acc + 11) @(negedge clk);
        u_if.abort = 1'b1;
        @(posedge clk); #1;
        u_if.abort = 1'b0;
        check("abort_busy", int'(u_if.busy), 0);
        check("abort_ready", int'(u_if.cmd_ready), 1);
        check("abort_count", int'(u_if.count), 0);
        repeat (6) @(negedge clk);
        check("abort_hold", int'(u_if.count), 0);
        check("abort_no_done", done_cnt - d0, 0);
        check("abort_sb_empty", sb.size(), 0);

        // LOAD 6 over count 3
        issue(2'd3, 3'd3, 3'd0, 8'd0, 8'd0, acc);
        wait_idle("load3_idle");
        issue(2'd3, 3'd6, 3'd0, 8'd0, 8'd0, acc);
        check("load_count", int'(u_if.count), 6);
        check("load_done", int'(u_if.done), 1);
        check("load_dir", int'(u_if.dir), 1);
        wait_idle("load6_idle");

        // Reset asserted mid-RUN
        mon_en = 1'b0;
        issue(2'd1, 3'd0, 3'd7, 8'd20, 8'd2, acc);
        repeat (5) @(negedge clk);
        check("pre_rst_busy", int'(u_if.busy), 1);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_count", int'(u_if.count), 0);
        check("midrst_dir", int'(u_if.dir), 1);
        check("midrst_busy", int'(u_if.busy), 0);
        check("midrst_ready", int'(u_if.cmd_ready), 1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
